// File: rtl/ppu_line_packer.sv
// Packs the PPU's serial 2-bit shade stream into two bit-plane line buffers and
// publishes each finished line to the VGA scan-out, held stable for its capture window.
module ppu_line_packer #(
   parameter int WIDTH       = 160,
   parameter int LINES       = 144,
   parameter int HOLD_CYCLES = 4
) (
   input  logic             pixelClk,
   input  logic             reset,
   input  logic             frameStart,
   input  logic             pixelValid,
   input  logic [1:0]       pixelData,
   output logic             pixelReady,
   output logic [WIDTH-1:0] LineBuffer0,
   output logic [WIDTH-1:0] LineBuffer1,
   output logic [7:0]       LY,
   output logic             updateBufferSignal,
   output logic             frameDone
);
   localparam int              HW        = $clog2(HOLD_CYCLES + 1);
   localparam logic [7:0]      LAST_X    = 8'(WIDTH - 1);
   localparam logic [7:0]      LAST_LINE = 8'(LINES - 1);
   localparam logic [HW-1:0]   HOLD_LOAD = HW'(HOLD_CYCLES);
   localparam logic [HW-1:0]   HOLD_ONE  = HW'(1);

   logic [WIDTH-1:0] work0;
   logic [WIDTH-1:0] work1;
   logic [7:0]       x;
   logic [7:0]       line_num;
   logic             line_complete;
   logic [HW-1:0]    hold_cnt;
   logic             accept;
   logic             publish;

   // Ready is forced low during reset even though line_complete clears there.
   assign pixelReady = !line_complete && !reset;
   assign accept     = pixelValid && pixelReady;
   assign publish    = line_complete && (hold_cnt == '0) && !frameStart;

   always_ff @(posedge pixelClk) begin
      if (reset) begin
         work0              <= '0;
         work1              <= '0;
         x                  <= '0;
         line_num           <= '0;
         line_complete      <= 1'b0;
         hold_cnt           <= '0;
         LineBuffer0        <= '0;
         LineBuffer1        <= '0;
         LY                 <= '0;
         updateBufferSignal <= 1'b0;
         frameDone          <= 1'b0;
      end else begin
         frameDone <= 1'b0;

         if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_ONE;
            if (hold_cnt == HOLD_ONE) begin
               updateBufferSignal <= 1'b0;
            end
         end

         // A frame restart drops any pending line; a pixel in the same cycle becomes x = 0.
         if (frameStart) begin
            line_num      <= '0;
            line_complete <= 1'b0;
            if (accept) begin
               work0[0] <= pixelData[0];
               work1[0] <= pixelData[1];
               x        <= 8'd1;
            end else begin
               x <= '0;
            end
         end else if (publish) begin
            LineBuffer0        <= work0;
            LineBuffer1        <= work1;
            LY                 <= line_num;
            updateBufferSignal <= 1'b1;
            hold_cnt           <= HOLD_LOAD;
            line_complete      <= 1'b0;
            x                  <= '0;
            line_num           <= (line_num == LAST_LINE) ? 8'd0 : line_num + 8'd1;
            frameDone          <= (line_num == LAST_LINE);
         end else if (accept) begin
            work0[x] <= pixelData[0];
            work1[x] <= pixelData[1];
            x        <= x + 8'd1;
            if (x == LAST_X) begin
               line_complete <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_ppu_line_packer.sv
// Scoreboard bench for ppu_line_packer: expected lines are queued as they are
// streamed in and compared when the packer publishes them.
module tb_ppu_line_packer;
   localparam int W      = 160;
   localparam int HOLD   = 4;
   localparam int HOLD_B = 200;

   typedef struct {
      logic [W-1:0] p0;
      logic [W-1:0] p1;
      logic [7:0]   ly;
      logic         fd;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic         reset, frame_start, pixel_valid, pixel_ready, upd, fd;
   logic [1:0]   pixel_data;
   logic [W-1:0] lb0, lb1;
   logic [7:0]   ly;

   logic         b_reset, b_fs, b_valid, b_ready, b_upd, b_fd;
   logic [1:0]   b_data;
   logic [W-1:0] b_lb0, b_lb1;
   logic [7:0]   b_ly;

   ppu_line_packer #(.WIDTH(W), .LINES(144), .HOLD_CYCLES(HOLD)) dut (
      .pixelClk(clk), .reset(reset), .frameStart(frame_start),
      .pixelValid(pixel_valid), .pixelData(pixel_data), .pixelReady(pixel_ready),
      .LineBuffer0(lb0), .LineBuffer1(lb1), .LY(ly),
      .updateBufferSignal(upd), .frameDone(fd)
   );

   ppu_line_packer #(.WIDTH(W), .LINES(144), .HOLD_CYCLES(HOLD_B)) dut_b (
      .pixelClk(clk), .reset(b_reset), .frameStart(b_fs),
      .pixelValid(b_valid), .pixelData(b_data), .pixelReady(b_ready),
      .LineBuffer0(b_lb0), .LineBuffer1(b_lb1), .LY(b_ly),
      .updateBufferSignal(b_upd), .frameDone(b_fd)
   );

   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];
   int   exp_line = 0;
   int   fd_cnt = 0;

   task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_pixel(input logic [1:0] d, input logic fs);
      int n;
      n = 0;
      pixel_valid = 1'b1;
      pixel_data  = d;
      frame_start = fs;
      while (!pixel_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) check_eq("ready_timeout", pixel_ready, 1'b1);
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic send_line(input int n_pix, input bit ramp, input bit fs, input bit push);
      logic [W-1:0] p0, p1;
      logic [1:0]   d;
      exp_t         ex;
      p0 = '0;
      p1 = '0;
      if (fs) exp_line = 0;
      for (int i = 0; i < n_pix; i++) begin
         d = ramp ? 2'(i % 4) : 2'($urandom_range(0, 3));
         p0[i] = d[0];
         p1[i] = d[1];
         send_pixel(d, fs && (i == 0));
      end
      pixel_valid = 1'b0;
      if (push) begin
         ex.p0 = p0;
         ex.p1 = p1;
         ex.ly = 8'(exp_line);
         ex.fd = (exp_line == 143);
         sb.push_back(ex);
         exp_line = (exp_line == 143) ? 0 : exp_line + 1;
      end
   endtask

   // Publish monitor: pops on each rising strobe, otherwise outputs must hold.
   initial begin
      logic         prev_upd;
      int           hi_cnt;
      logic [W-1:0] last0, last1;
      logic [7:0]   last_ly;
      exp_t         e;
      prev_upd = 1'b0;
      hi_cnt   = 0;
      last0    = '0;
      last1    = '0;
      last_ly  = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_upd = 1'b0;
            hi_cnt   = 0;
            last0    = '0;
            last1    = '0;
            last_ly  = '0;
         end else begin
            if (upd && !prev_upd) begin
               if (sb.size() == 0) begin
                  check_eq("pub_expected", sb.size(), 1);
               end else begin
                  e = sb.pop_front();
                  check_eq("pub_lb0", lb0, e.p0);
                  check_eq("pub_lb1", lb1, e.p1);
                  check_eq("pub_ly", ly, e.ly);
                  check_eq("pub_fd", fd, e.fd);
               end
               last0   = lb0;
               last1   = lb1;
               last_ly = ly;
               hi_cnt  = 1;
            end else begin
               check_eq("hold_lb0", lb0, last0);
               check_eq("hold_lb1", lb1, last1);
               check_eq("hold_ly", ly, last_ly);
               check_eq("fd_idle", fd, 1'b0);
               if (upd) hi_cnt++;
               else if (prev_upd) check_eq("upd_len", hi_cnt, HOLD);
            end
            if (fd) fd_cnt++;
            prev_upd = upd;
         end
      end
   end

   initial begin
      int t0, t1, n, acc, stall;
      reset = 1'b1; frame_start = 1'b0; pixel_valid = 1'b0; pixel_data = 2'b00;
      b_reset = 1'b1; b_fs = 1'b0; b_valid = 1'b0; b_data = 2'b00;

      repeat (3) @(negedge clk);
      check_eq("rst_ready", pixel_ready, 1'b0);
      check_eq("rst_lb0", lb0, '0);
      check_eq("rst_lb1", lb1, '0);
      check_eq("rst_ly", ly, 8'd0);
      check_eq("rst_upd", upd, 1'b0);
      check_eq("rst_fd", fd, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      check_eq("ready_after_rst", pixel_ready, 1'b1);

      // Line 0: pixel x = x mod 4.
      send_line(W, 1, 0, 1);
      check_eq("ready_line_full", pixel_ready, 1'b0);
      check_eq("upd_before_pub", upd, 1'b0);
      @(negedge clk);
      check_eq("pub_latency", upd, 1'b1);
      check_eq("line0_lb0", lb0, {40{4'hA}});
      check_eq("line0_lb1", lb1, {40{4'hC}});
      check_eq("line0_ly", ly, 8'd0);
      t0 = cyc;

      // Back-to-back line: minimum period of W+1 edges, no stall.
      send_line(W, 0, 0, 1);
      @(negedge clk);
      check_eq("line1_period", cyc - t0, W + 1);
      check_eq("line1_upd", upd, 1'b1);
      check_eq("line1_ly", ly, 8'd1);

      // Rest of the frame plus the wrap back to LY = 0.
      for (int k = 2; k <= 144; k++) send_line(W, 0, 0, 1);
      repeat (2) @(negedge clk);
      check_eq("frame_done_count", fd_cnt, 1);
      check_eq("wrap_ly", ly, 8'd0);

      // Lines 1..4, a partial line 5, then a frame restart carrying its first pixel.
      for (int k = 1; k <= 4; k++) send_line(W, 0, 0, 1);
      send_line(70, 0, 0, 0);
      send_line(W, 0, 1, 1);
      repeat (3) @(negedge clk);
      check_eq("restart_ly", ly, 8'd0);
      check_eq("upd_mid_hold", upd, 1'b1);

      // Reset two cycles before the hold would end.
      reset = 1'b1;
      @(negedge clk);
      check_eq("midrst_lb0", lb0, '0);
      check_eq("midrst_lb1", lb1, '0);
      check_eq("midrst_ly", ly, 8'd0);
      check_eq("midrst_upd", upd, 1'b0);
      check_eq("midrst_ready", pixel_ready, 1'b0);
      reset = 1'b0;
      exp_line = 0;
      @(negedge clk);
      check_eq("midrst_ready_after", pixel_ready, 1'b1);
      send_line(W, 1, 0, 1);
      repeat (8) @(negedge clk);
      check_eq("sb_drain", sb.size(), 0);
      check_eq("frame_done_total", fd_cnt, 1);

      // Long hold: the hold window plus one idle edge separates the publishes.
      b_reset = 1'b0;
      b_valid = 1'b1;
      b_data  = 2'b10;
      n = 0;
      while (!b_upd && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_eq("b_pub1", b_upd, 1'b1);
      check_eq("b_pub1_lb0", b_lb0, '0);
      check_eq("b_pub1_lb1", b_lb1, {W{1'b1}});
      t1 = cyc;
      b_data = 2'b01;
      acc = 0;
      stall = 0;
      n = 0;
      while (b_ly != 8'd1 && n < 400) begin
         if (b_ready) acc++;
         else stall++;
         @(negedge clk);
         n++;
      end
      check_eq("b_pub_spacing", cyc - t1, HOLD_B + 1);
      check_eq("b_accepts", acc, W);
      check_eq("b_stall", stall, HOLD_B + 1 - W);
      check_eq("b_pub2_upd", b_upd, 1'b1);
      check_eq("b_pub2_lb0", b_lb0, {W{1'b1}});
      check_eq("b_pub2_lb1", b_lb1, '0);
      b_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
